multi_rect_renderer: RTL and testbench
======================================

// Module: multi_rect_renderer
// PURPOSE
// - Parametrised successor to the single fixed red-square test pattern.
// - Draws NUM_RECTS overlapping, independently coloured rectangles on a 640x480 VGA raster.
// - Each rectangle has runtime-programmable position, size, colour and optional per-frame bounce motion.
// - Instantiates vga_controller for timing. Sits between the board pins and the game-logic config master.
// PARAMETERS
// - NUM_RECTS  4        rectangle count, 1..8; index 0 has highest priority
// - H_ACTIVE   640      visible width; pixels with x_count >= H_ACTIVE are blank
// - V_ACTIVE   480      visible height; pixels with y_count >= V_ACTIVE are blank
// - BG_COLOR   6'h00    background {r,g,b} colour for active-area pixels no rectangle covers
// PORTS
// - clk_25MHz  in   1   pixel clock
// - rst_n      in   1   asynchronous, active-low reset
// - cfg_we     in   1   config write strobe, one write per cycle
// - cfg_idx    in   3   rectangle index; writes with idx >= NUM_RECTS are ignored
// - cfg_field  in   3   0:x 1:y 2:w 3:h 4:colour[5:0] 5:motion; values 6-7 are ignored
// - cfg_wdata  in   10  write data; motion = {dy_spd[6:4], dx_spd[3:1], move_en[0]}
// - frame_tick out  1   1-cycle pulse at the commit/motion update (x_count==0 && y_count==V_ACTIVE)
// - vga_hsync  out  1   hsync, delayed 2 cycles to match colour
// - vga_vsync  out  1   vsync, delayed 2 cycles to match colour
// - vga_r/g/b  out  2 each  pixel colour, registered
// BEHAVIOUR
// - Reset values:
//   - vga_r/g/b = 0; frame_tick = 0; hsync/vsync pipeline = 1 (inactive).
//   - Direction bits = +x/+y.
//   - Rect 0 = x270 y190 w100 h100 colour 6'b110000, motion 0, so the power-up image is the legacy red square.
//   - All other rects: w=h=0 (invisible), colour 0, motion 0.
//   - Shadow registers equal the active registers; all dirty flags are cleared.
// - Config writes go to shadow registers only. A written field sets that field's dirty flag.
// - Commit on frame_tick:
//   - Each dirty field is copied shadow -> active and its flag is cleared.
//   - A write in the same cycle as frame_tick lands in shadow and commits at the next tick.
// - Motion on frame_tick, per rect with move_en=1, for any x/y not committed this tick:
//   - Arithmetic is 11-bit unsigned.
//   - +x direction: if x+w+dx_spd >= H_ACTIVE then x = H_ACTIVE-w and the direction flips to -x; else x += dx_spd.
//   - -x direction: if x < dx_spd then x = 0 and the direction flips to +x; else x -= dx_spd.
//   - y uses the same rules with h, dy_spd and V_ACTIVE.
//   - speed=0 means no motion on that axis.
//   - If w > H_ACTIVE, x clamps to 0 with no flip.
// - Hit test: rect i covers a pixel when w != 0, h != 0, x <= xc < x+w and y <= yc < y+h.
//   - Compare in 11 bits; no wrap-around, so rects clip at the raster edge.
// - Pipeline:
//   - S1 registers the per-rect hit vector and the active flag (xc < H_ACTIVE && yc < V_ACTIVE).
//   - S2 registers the colour: blank (0) outside active video; else the lowest-index hit colour; else BG_COLOR.
//   - Latency from x/y counts to RGB is 2 cycles; hsync/vsync are delayed identically.
// - Active registers change only at frame_tick, so there is no tearing within a frame.
// - Reset asserted mid-frame returns everything to the reset values immediately, including pending shadow writes.
// TESTING
// - Reset release, no writes -> red 2'b11 exactly on x270..369, y190..289; all else 0; sync-to-RGB alignment holds.
// - Write rect1 x=300 y=200 w=50 h=50 colour 6'h0C mid-frame -> unchanged until the next frame_tick.
//   - After the tick, the overlap shows red (rect0 wins); the rest of rect1 is green.
// - rect0 motion dx_spd=4, x=530, w=100 -> after ticks x=534, 538, then 540 with a flip; the next tick gives 536.
// - cfg_we on the frame_tick cycle with x=10 -> x is unchanged that tick and equals 10 after the following tick.
// - Write w=0 for rect0 and BG_COLOR = 6'h03 -> the whole active area is blue, and blanking stays 0.
// - Write with cfg_idx=7 (NUM_RECTS=4) or cfg_field=6 -> no state change.
// - Reset pulsed mid-line -> outputs 0 within the reset cycle, and the legacy square returns.

Source files
------------

// File: rtl/multi_rect_renderer.sv
// rtl/multi_rect_renderer.sv - multi-rectangle VGA renderer with shadowed config and per-frame bounce motion
// Includes the raster timing generator it is built on.

module vga_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    output logic [9:0] x_count,
    output logic [9:0] y_count,
    output logic       hsync,
    output logic       vsync
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic [9:0] x_count_q, x_count_d;
    logic [9:0] y_count_q, y_count_d;

    always_comb begin
        x_count_d = x_count_q + 10'd1;
        y_count_d = y_count_q;
        if (x_count_q == 10'(H_TOTAL - 1)) begin
            x_count_d = '0;
            y_count_d = (y_count_q == 10'(V_TOTAL - 1)) ? '0 : y_count_q + 10'd1;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            x_count_q <= '0;
            y_count_q <= '0;
        end else begin
            x_count_q <= x_count_d;
            y_count_q <= y_count_d;
        end
    end

    assign x_count = x_count_q;
    assign y_count = y_count_q;
    // Sync pulses are active-low
    assign hsync = !((x_count_q >= 10'(H_ACTIVE + H_FRONT)) &&
                     (x_count_q <  10'(H_ACTIVE + H_FRONT + H_SYNC)));
    assign vsync = !((y_count_q >= 10'(V_ACTIVE + V_FRONT)) &&
                     (y_count_q <  10'(V_ACTIVE + V_FRONT + V_SYNC)));
endmodule

module multi_rect_renderer #(
    parameter int          NUM_RECTS = 4,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter logic [5:0]  BG_COLOR  = 6'h00,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [2:0] cfg_idx,
    input  logic [2:0] cfg_field,
    input  logic [9:0] cfg_wdata,
    output logic       frame_tick,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b
);
    localparam logic [9:0] HA10 = 10'(H_ACTIVE);
    localparam logic [9:0] VA10 = 10'(V_ACTIVE);

    logic [9:0] x_count, y_count;
    logic       hsync, vsync;

    vga_controller #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_vga (
        .clk_25MHz(clk_25MHz),
        .rst_n    (rst_n),
        .x_count  (x_count),
        .y_count  (y_count),
        .hsync    (hsync),
        .vsync    (vsync)
    );

    // Geometry fields 0..3 = x, y, w, h; dir bit set means moving towards 0
    logic [9:0] pos_q    [NUM_RECTS][4];
    logic [9:0] pos_d    [NUM_RECTS][4];
    logic [9:0] sh_pos_q [NUM_RECTS][4];
    logic [9:0] sh_pos_d [NUM_RECTS][4];
    logic [5:0] col_q    [NUM_RECTS];
    logic [5:0] col_d    [NUM_RECTS];
    logic [5:0] sh_col_q [NUM_RECTS];
    logic [5:0] sh_col_d [NUM_RECTS];
    logic [6:0] mot_q    [NUM_RECTS];
    logic [6:0] mot_d    [NUM_RECTS];
    logic [6:0] sh_mot_q [NUM_RECTS];
    logic [6:0] sh_mot_d [NUM_RECTS];
    logic [5:0] dirty_q  [NUM_RECTS];
    logic [5:0] dirty_d  [NUM_RECTS];
    logic [1:0] dir_q    [NUM_RECTS];
    logic [1:0] dir_d    [NUM_RECTS];

    logic [NUM_RECTS-1:0] hit_q, hit_d;
    logic                 active_q, active_d;
    logic [5:0]           rgb_q, rgb_d;
    logic [1:0]           hs_pipe_q, hs_pipe_d;
    logic [1:0]           vs_pipe_q, vs_pipe_d;
    logic [10:0]          x_step, y_step;

    function automatic logic [9:0] rst_geom(input int i, input int f);
        logic [9:0] v;
        v = '0;
        if (i == 0) begin
            case (f)
                0:       v = 10'd270;
                1:       v = 10'd190;
                default: v = 10'd100;
            endcase
        end
        return v;
    endfunction

    // Returns {flip, new_pos}; all reach arithmetic is 11-bit unsigned
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic [9:0] len,
                                              input logic [2:0] spd, input logic neg,
                                              input logic [9:0] lim);
        logic [10:0] reach;
        logic [10:0] res;
        reach = {1'b0, pos} + {1'b0, len} + {8'b0, spd};
        res   = {1'b0, pos};
        if (spd != 3'd0) begin
            if (len > lim) begin
                res = '0;
            end else if (!neg) begin
                if (reach >= {1'b0, lim}) res = {1'b1, lim - len};
                else                      res = {1'b0, pos + {7'b0, spd}};
            end else begin
                if (pos < {7'b0, spd}) res = {1'b1, 10'd0};
                else                   res = {1'b0, pos - {7'b0, spd}};
            end
        end
        return res;
    endfunction

    assign frame_tick = (x_count == 10'd0) && (y_count == VA10);

    always_comb begin
        pos_d    = pos_q;
        sh_pos_d = sh_pos_q;
        col_d    = col_q;
        sh_col_d = sh_col_q;
        mot_d    = mot_q;
        sh_mot_d = sh_mot_q;
        dirty_d  = dirty_q;
        dir_d    = dir_q;
        x_step   = '0;
        y_step   = '0;
        if (frame_tick) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                // Motion uses pre-tick geometry; a committed coordinate overrides it
                if (mot_q[i][0]) begin
                    x_step = step_axis(pos_q[i][0], pos_q[i][2], mot_q[i][3:1], dir_q[i][0], HA10);
                    y_step = step_axis(pos_q[i][1], pos_q[i][3], mot_q[i][6:4], dir_q[i][1], VA10);
                    if (!dirty_q[i][0]) begin
                        pos_d[i][0] = x_step[9:0];
                        dir_d[i][0] = dir_q[i][0] ^ x_step[10];
                    end
                    if (!dirty_q[i][1]) begin
                        pos_d[i][1] = y_step[9:0];
                        dir_d[i][1] = dir_q[i][1] ^ y_step[10];
                    end
                end
                for (int f = 0; f < 4; f++) begin
                    if (dirty_q[i][f]) pos_d[i][f] = sh_pos_q[i][f];
                end
                if (dirty_q[i][4]) col_d[i] = sh_col_q[i];
                if (dirty_q[i][5]) mot_d[i] = sh_mot_q[i];
                dirty_d[i] = '0;
            end
        end
        if (cfg_we) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (cfg_idx == 3'(i)) begin
                    case (cfg_field)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            sh_pos_d[i][cfg_field[1:0]] = cfg_wdata;
                            dirty_d[i][cfg_field]       = 1'b1;
                        end
                        3'd4: begin
                            sh_col_d[i]   = cfg_wdata[5:0];
                            dirty_d[i][4] = 1'b1;
                        end
                        3'd5: begin
                            sh_mot_d[i]   = cfg_wdata[6:0];
                            dirty_d[i][5] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
            hit_d[i] = (pos_q[i][2] != '0) && (pos_q[i][3] != '0) &&
                       ({1'b0, x_count} >= {1'b0, pos_q[i][0]}) &&
                       ({1'b0, x_count} <  ({1'b0, pos_q[i][0]} + {1'b0, pos_q[i][2]})) &&
                       ({1'b0, y_count} >= {1'b0, pos_q[i][1]}) &&
                       ({1'b0, y_count} <  ({1'b0, pos_q[i][1]} + {1'b0, pos_q[i][3]}));
        end
        active_d = (x_count < HA10) && (y_count < VA10);
        rgb_d    = '0;
        if (active_q) begin
            rgb_d = BG_COLOR;
            // Walk from the highest index down so index 0 ends up on top
            for (int i = NUM_RECTS - 1; i >= 0; i--) begin
                if (hit_q[i]) rgb_d = col_q[i];
            end
        end
        hs_pipe_d = {hs_pipe_q[0], hsync};
        vs_pipe_d = {vs_pipe_q[0], vsync};
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                for (int f = 0; f < 4; f++) begin
                    pos_q[i][f]    <= rst_geom(i, f);
                    sh_pos_q[i][f] <= rst_geom(i, f);
                end
                col_q[i]    <= (i == 0) ? 6'b110000 : 6'h00;
                sh_col_q[i] <= (i == 0) ? 6'b110000 : 6'h00;
                mot_q[i]    <= '0;
                sh_mot_q[i] <= '0;
                dirty_q[i]  <= '0;
                dir_q[i]    <= '0;
            end
            hit_q     <= '0;
            active_q  <= 1'b0;
            rgb_q     <= '0;
            hs_pipe_q <= 2'b11;
            vs_pipe_q <= 2'b11;
        end else begin
            pos_q     <= pos_d;
            sh_pos_q  <= sh_pos_d;
            col_q     <= col_d;
            sh_col_q  <= sh_col_d;
            mot_q     <= mot_d;
            sh_mot_q  <= sh_mot_d;
            dirty_q   <= dirty_d;
            dir_q     <= dir_d;
            hit_q     <= hit_d;
            active_q  <= active_d;
            rgb_q     <= rgb_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
        end
    end

    assign vga_r     = rgb_q[5:4];
    assign vga_g     = rgb_q[3:2];
    assign vga_b     = rgb_q[1:0];
    assign vga_hsync = hs_pipe_q[1];
    assign vga_vsync = vs_pipe_q[1];
endmodule

// File: tb/tb_multi_rect_renderer.sv
// tb/tb_multi_rect_renderer.sv - self-checking bench for multi_rect_renderer on a reduced raster

module tb_multi_rect_renderer;
    localparam int NR = 4;
    localparam int HA = 48, HF = 2, HS = 4, HB = 2;
    localparam int VA = 32, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [5:0] BG = 6'h03;

    logic       clk_25MHz = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [2:0] cfg_field;
    logic [9:0] cfg_wdata;
    logic       frame_tick, vga_hsync, vga_vsync;
    logic [1:0] vga_r, vga_g, vga_b;

    multi_rect_renderer #(
        .NUM_RECTS(NR), .H_ACTIVE(HA), .V_ACTIVE(VA), .BG_COLOR(BG),
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_field (cfg_field),
        .cfg_wdata (cfg_wdata),
        .frame_tick(frame_tick),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    typedef struct {
        int         px;
        int         py;
        logic [5:0] rgb;
    } probe_t;

    // Reference model: active/shadow field tables per rect, fields 0..5 = x y w h colour motion
    int         act [NR][6];
    int         shd [NR][6];
    bit         drt [NR][6];
    bit         dxn [NR];
    bit         dyn [NR];
    int         cx, cy;
    logic [5:0] e1, e2;
    bit         hs1, hs2, vs1, vs2;
    int         ox1, oy1, ox2, oy2;
    bit         last_tick;
    int         checks, errors;

    function automatic logic [5:0] pixel(int x, int y);
        if (x >= HA || y >= VA) return 6'h00;
        for (int i = 0; i < NR; i++) begin
            if (act[i][2] != 0 && act[i][3] != 0 &&
                x >= act[i][0] && x < act[i][0] + act[i][2] &&
                y >= act[i][1] && y < act[i][1] + act[i][3])
                return 6'(act[i][4]);
        end
        return BG;
    endfunction

    function automatic int move(int pos, int len, int spd, int lim, bit neg, output bit flip);
        flip = 1'b0;
        if (spd == 0) return pos;
        if (len > lim) return 0;
        if (!neg) begin
            if (((pos + len + spd) % 2048) >= lim) begin
                flip = 1'b1;
                return lim - len;
            end
            return (pos + spd) % 1024;
        end
        if (pos < spd) begin
            flip = 1'b1;
            return 0;
        end
        return pos - spd;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            for (int f = 0; f < 6; f++) begin
                act[i][f] = 0;
                drt[i][f] = 1'b0;
            end
            dxn[i] = 1'b0;
            dyn[i] = 1'b0;
        end
        act[0][0] = 270; act[0][1] = 190; act[0][2] = 100; act[0][3] = 100; act[0][4] = 'h30;
        shd = act;
        cx = 0; cy = 0;
        e1 = '0; e2 = '0;
        hs1 = 1'b1; hs2 = 1'b1; vs1 = 1'b1; vs2 = 1'b1;
        ox1 = -1; oy1 = -1; ox2 = -1; oy2 = -1;
        last_tick = 1'b0;
    endtask

    task automatic model_edge();
        int old [NR][6];
        bit tick, f;
        int spd, np, mask;
        tick      = (cx == 0 && cy == VA);
        last_tick = tick;
        e2 = e1;  e1 = pixel(cx, cy);
        hs2 = hs1; hs1 = !(cx >= HA + HF && cx < HA + HF + HS);
        vs2 = vs1; vs1 = !(cy >= VA + VF && cy < VA + VF + VS);
        ox2 = ox1; ox1 = cx; oy2 = oy1; oy1 = cy;
        if (tick) begin
            old = act;
            for (int r = 0; r < NR; r++) begin
                if (old[r][5] % 2 == 1) begin
                    spd = (old[r][5] / 2) % 8;
                    np  = move(old[r][0], old[r][2], spd, HA, dxn[r], f);
                    if (!drt[r][0]) begin act[r][0] = np; if (f) dxn[r] = !dxn[r]; end
                    spd = (old[r][5] / 16) % 8;
                    np  = move(old[r][1], old[r][3], spd, VA, dyn[r], f);
                    if (!drt[r][1]) begin act[r][1] = np; if (f) dyn[r] = !dyn[r]; end
                end
                for (int k = 0; k < 6; k++) begin
                    if (drt[r][k]) act[r][k] = shd[r][k];
                    drt[r][k] = 1'b0;
                end
            end
        end
        if (cfg_we && int'(cfg_idx) < NR && int'(cfg_field) < 6) begin
            mask = (cfg_field == 3'd4) ? 63 : (cfg_field == 3'd5) ? 127 : 1023;
            shd[cfg_idx][cfg_field] = int'(cfg_wdata) & mask;
            drt[cfg_idx][cfg_field] = 1'b1;
        end
        cx = cx + 1;
        if (cx == HT) begin
            cx = 0;
            cy = (cy + 1) % VT;
        end
    endtask

    // Called just after a falling edge: check outputs, apply one rising edge, then drop the strobe
    task automatic step();
        bit t;
        t = (cx == 0 && cy == VA);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick} !== {e2, hs2, vs2, t}) begin
            errors++;
            $display("FAIL cycle_check pix(%0d,%0d): rgb=%h hs=%b vs=%b tick=%b required rgb=%h hs=%b vs=%b tick=%b",
                     ox2, oy2, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, frame_tick, e2, hs2, vs2, t);
        end
        @(posedge clk_25MHz);
        model_edge();
        @(negedge clk_25MHz);
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input int idx, input int field, input int data);
        cfg_we    = 1'b1;
        cfg_idx   = 3'(idx);
        cfg_field = 3'(field);
        cfg_wdata = 10'(data);
        step();
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        last_tick = 1'b0;
        while (!last_tick && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (!last_tick) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame_tick within %0d cycles", name, 2 * FRAME);
        end
    endtask

    task automatic probe(input string name, input int px, input int py, input logic [5:0] exp);
        int n;
        n = 0;
        while (!(ox2 == px && oy2 == py) && n < 2 * FRAME) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2 * FRAME) begin
            errors++;
            $display("FAIL %s: pixel (%0d,%0d) never reached the output", name, px, py);
        end else if ({vga_r, vga_g, vga_b} !== exp) begin
            errors++;
            $display("FAIL %s: pixel (%0d,%0d) rgb=%h required %h", name, px, py, {vga_r, vga_g, vga_b}, exp);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, frame_tick} !== 9'b000000_110) begin
            errors++;
            $display("FAIL %s: rgb=%h hs=%b vs=%b tick=%b required rgb=00 hs=1 vs=1 tick=0",
                     name, {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync, frame_tick);
        end
    endtask

    initial begin
        probe_t tbl [13];
        int     xs  [5];
        int     n;

        tbl[0]  = '{0,  0,  6'h03};
        tbl[1]  = '{19, 10, 6'h03};
        tbl[2]  = '{20, 10, 6'h30};
        tbl[3]  = '{30, 10, 6'h03};
        tbl[4]  = '{25, 15, 6'h30};
        tbl[5]  = '{30, 15, 6'h0C};
        tbl[6]  = '{29, 19, 6'h30};
        tbl[7]  = '{34, 24, 6'h0C};
        tbl[8]  = '{35, 24, 6'h03};
        tbl[9]  = '{34, 25, 6'h03};
        tbl[10] = '{47, 31, 6'h03};
        tbl[11] = '{48, 31, 6'h00};
        tbl[12] = '{0,  32, 6'h00};
        xs[0] = 30; xs[1] = 34; xs[2] = 38; xs[3] = 34; xs[4] = 30;

        checks = 0; errors = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk_25MHz);
        check_reset("reset_state");
        rst_n = 1'b1;

        // Power-up frame: legacy square lies off this small raster, so all background
        wait_tick("boot_tick");

        // Mid-frame writes stay in shadow until the next tick
        cfg(0, 0, 20); cfg(0, 1, 10); cfg(0, 2, 10); cfg(0, 3, 10);
        cfg(1, 0, 25); cfg(1, 1, 15); cfg(1, 2, 10); cfg(1, 3, 10); cfg(1, 4, 'h0C);
        probe("pre_commit", 30, 15, 6'h03);
        wait_tick("commit_tick");
        for (int i = 0; i < 13; i++) probe($sformatf("table_%0d", i), tbl[i].px, tbl[i].py, tbl[i].rgb);

        // Bounce on x: dx_spd=4, w=10 against a 48-pixel line
        cfg(0, 0, 30);
        cfg(0, 5, 9);
        for (int k = 0; k < 5; k++) begin
            wait_tick("motion_tick");
            probe($sformatf("motion_left_%0d", k), xs[k] - 1, 12, 6'h03);
            probe($sformatf("motion_edge_%0d", k), xs[k], 12, 6'h30);
        end
        cfg(0, 5, 0);

        // Write landing on the tick cycle waits one more frame
        cfg(2, 1, 25); cfg(2, 2, 5); cfg(2, 3, 5); cfg(2, 4, 'h3F);
        wait_tick("rect2_tick");
        probe("rect2_at0", 0, 25, 6'h3F);
        n = 0;
        while (!(cx == 0 && cy == VA) && n < 2 * FRAME) begin step(); n++; end
        cfg(2, 0, 10);
        probe("ontick_old0", 0, 25, 6'h3F);
        probe("ontick_old10", 10, 25, 6'h03);
        wait_tick("ontick_next");
        probe("ontick_new0", 0, 25, 6'h03);
        probe("ontick_new10", 10, 25, 6'h3F);

        // Out-of-range index and field are dropped
        cfg(7, 0, 5); cfg(4, 2, 0); cfg(1, 6, 0); cfg(1, 7, 3);
        wait_tick("ignored_tick");
        probe("ignored_rect1", 30, 22, 6'h0C);

        // Reset mid-line
        n = 0;
        while (!(cx == 30 && cy == 5) && n < 2 * FRAME) begin step(); n++; end
        rst_n = 1'b0;
        #1;
        check_reset("midline_reset");
        model_reset();
        @(posedge clk_25MHz);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        wait_tick("post_reset_tick");
        probe("reset_rect1_gone", 30, 22, 6'h03);

        // Random config traffic against the model
        for (int k = 0; k < 6 * FRAME; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg_we    = 1'b1;
                cfg_idx   = 3'($urandom_range(0, 7));
                cfg_field = 3'($urandom_range(0, 7));
                cfg_wdata = (cfg_field < 3'd4) ? 10'($urandom_range(0, 60)) : 10'($urandom_range(0, 1023));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
